// File: rtl/pipe_scroller_if.sv
// ---------------------------------------------------------------------------
// pipe_scroller_if
//    Height request handshake between the pipe scroller and the random
//    height generator.
//
//    height_req  scroller -> generator   request for a new height (registered)
//    height_ack  generator -> scroller   height_in is valid this cycle
//    height_in   generator -> scroller   8-bit random height value
//
//    master: the scroller (issues requests)
//    slave : the height generator (answers requests)
// ---------------------------------------------------------------------------
interface pipe_scroller_if;
   logic       height_req;
   logic       height_ack;
   logic [7:0] height_in;

   modport master (output height_req, input height_ack, input height_in);
   modport slave  (input height_req, output height_ack, output height_in);
endinterface

// File: rtl/pipe_scroller.sv
// ---------------------------------------------------------------------------
// pipe_scroller
//    Scrolls one pipe leftward by SPEED pixels per frame_tick. When the pipe
//    has fully left the screen it requests a new random height over the
//    req/ack handshake and respawns at the right edge. Emits the vertical
//    gap bounds and a one-cycle score pulse when the pipe clears the bird.
//
// Ports
//    clk         system clock
//    reset       asynchronous, active-high reset
//    run         game running; 0 freezes scrolling (not the handshake)
//    frame_tick  one-cycle pulse per video frame
//    hs          height handshake (master side: height_req/ack/in)
//    pipe_x      signed left edge of the pipe in pixels
//    gap_top     y of the top of the opening
//    gap_bot     y of the bottom of the opening (gap_top + GAP)
//    passed      one-cycle pulse when the pipe's right edge reaches BIRD_X
//    busy        high while waiting for a height (REQ state)
//    All outputs are registered.
// ---------------------------------------------------------------------------
module pipe_scroller #(
   parameter int SCREEN_W = 640,
   parameter int PIPE_W   = 64,
   parameter int SPEED    = 2,
   parameter int GAP      = 120,
   parameter int MIN_TOP  = 40,
   parameter int RANGE    = 240,
   parameter int BIRD_X   = 160
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                run,
   input  logic                frame_tick,
   pipe_scroller_if.master     hs,
   output logic signed [10:0]  pipe_x,
   output logic        [8:0]   gap_top,
   output logic        [8:0]   gap_bot,
   output logic                passed,
   output logic                busy
);

   typedef enum logic [1:0] {IDLE, REQ, SCROLL} state_t;

   // Signed constants keep every position comparison in signed arithmetic.
   localparam logic signed [10:0] PIPE_W_S = 11'(PIPE_W);
   localparam logic signed [10:0] BIRD_X_S = 11'(BIRD_X);
   localparam logic signed [10:0] SPEED_S  = 11'(SPEED);
   localparam logic signed [10:0] RESPAWN  = 11'(SCREEN_W);
   localparam logic        [8:0]  TOP_RST  = 9'(MIN_TOP + RANGE / 2);
   localparam logic        [8:0]  BOT_RST  = 9'(MIN_TOP + RANGE / 2 + GAP);

   state_t                state;
   logic signed [10:0]    nx;
   logic        [15:0]    prod;
   logic        [8:0]     top_new;
   logic                  offscreen;
   logic                  crossing;

   // NOTE: every signal written in always_comb is assigned on every path
   // (here unconditionally), so no latch can be inferred.
   always_comb begin
      nx        = pipe_x - SPEED_S;
      // Scale the 8-bit random value onto 0..RANGE-1 above MIN_TOP.
      prod      = 16'(hs.height_in) * 16'(RANGE);
      top_new   = 9'(16'(MIN_TOP) + (prod >> 8));
      offscreen = (nx + PIPE_W_S) <= 11'sd0;
      // Right edge moves from beyond the bird to at-or-behind it this step.
      crossing  = ((pipe_x + PIPE_W_S) > BIRD_X_S) && ((nx + PIPE_W_S) <= BIRD_X_S);
   end

   // NOTE: state registers use non-blocking assignments so every register
   // samples the pre-edge values, regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         pipe_x        <= RESPAWN;
         gap_top       <= TOP_RST;
         gap_bot       <= BOT_RST;
         hs.height_req <= 1'b0;
         passed        <= 1'b0;
         busy          <= 1'b0;
      end else begin
         passed <= 1'b0;
         case (state)
            IDLE: begin
               if (frame_tick && run) begin
                  state         <= REQ;
                  hs.height_req <= 1'b1;
                  busy          <= 1'b1;
               end
            end

            // run and frame_tick are ignored here; only the ack matters.
            REQ: begin
               if (hs.height_ack && hs.height_req) begin
                  gap_top       <= top_new;
                  gap_bot       <= top_new + 9'(GAP);
                  pipe_x        <= RESPAWN;
                  hs.height_req <= 1'b0;
                  busy          <= 1'b0;
                  state         <= SCROLL;
               end
            end

            SCROLL: begin
               if (frame_tick && run) begin
                  pipe_x <= nx;
                  if (crossing) passed <= 1'b1;
                  // The final scroll step and the new request share one edge.
                  if (offscreen) begin
                     state         <= REQ;
                     hs.height_req <= 1'b1;
                     busy          <= 1'b1;
                  end
               end
            end

            default: begin
               state         <= IDLE;
               hs.height_req <= 1'b0;
               busy          <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pipe_scroller.sv
// ---------------------------------------------------------------------------
// tb_pipe_scroller
//    Directed self-checking bench for pipe_scroller with default parameters.
//    Expected gap bounds are pushed to a scoreboard queue when an ack is
//    driven and popped when the load completes; pipe position, score pulse
//    and request are predicted by a small scroll model.
// ---------------------------------------------------------------------------
module tb_pipe_scroller;

   typedef struct {
      logic [8:0] top;
      logic [8:0] bot;
   } gap_t;

   logic               clk;
   logic               reset;
   logic               run;
   logic               frame_tick;
   logic signed [10:0] pipe_x;
   logic [8:0]         gap_top;
   logic [8:0]         gap_bot;
   logic               passed;
   logic               busy;

   pipe_scroller_if hs_if ();

   pipe_scroller dut (
      .clk        (clk),
      .reset      (reset),
      .run        (run),
      .frame_tick (frame_tick),
      .hs         (hs_if),
      .pipe_x     (pipe_x),
      .gap_top    (gap_top),
      .gap_bot    (gap_bot),
      .passed     (passed),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   int   pass_cnt = 0;
   int   exp_x = 640;
   gap_t sb[$];

   // Counts clock cycles on which the score pulse is high.
   always @(posedge clk) if (!reset && passed) pass_cnt <= pass_cnt + 1;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One frame tick while scrolling with run=1; predicts the scroll step.
   task automatic tick_scroll(input string tag);
      int  old_x;
      bit  exp_pass;
      bit  exp_req;
      old_x    = exp_x;
      exp_x    = old_x - 2;
      exp_pass = (old_x + 64 > 160) && (exp_x + 64 <= 160);
      exp_req  = (exp_x + 64 <= 0);
      @(negedge clk) frame_tick = 1'b1;
      @(negedge clk) frame_tick = 1'b0;
      check({tag, "_x"},      int'(pipe_x), exp_x);
      check({tag, "_passed"}, int'(passed), int'(exp_pass));
      check({tag, "_req"},    int'(hs_if.height_req), int'(exp_req));
      check({tag, "_busy"},   int'(busy), int'(exp_req));
      if (exp_pass) begin
         @(negedge clk);
         check({tag, "_pass_width"}, int'(passed), 0);
      end
   endtask

   // Drive a one-cycle ack (optionally together with a frame tick) and
   // check the completed load against the scoreboard.
   task automatic do_ack(input string tag, input int h, input bit with_tick);
      gap_t e;
      gap_t got;
      e.top = 9'(40 + (h * 240) / 256);
      e.bot = 9'(40 + (h * 240) / 256 + 120);
      @(negedge clk);
      hs_if.height_ack = 1'b1;
      hs_if.height_in  = 8'(h);
      frame_tick       = with_tick;
      sb.push_back(e);
      @(negedge clk);
      hs_if.height_ack = 1'b0;
      hs_if.height_in  = 8'hA5;
      frame_tick       = 1'b0;
      got = sb.pop_front();
      exp_x = 640;
      check({tag, "_gap_top"}, int'(gap_top), int'(got.top));
      check({tag, "_gap_bot"}, int'(gap_bot), int'(got.bot));
      check({tag, "_x"},       int'(pipe_x), 640);
      check({tag, "_req"},     int'(hs_if.height_req), 0);
      check({tag, "_busy"},    int'(busy), 0);
   endtask

   initial begin
      reset            = 1'b1;
      run              = 1'b0;
      frame_tick       = 1'b0;
      hs_if.height_ack = 1'b0;
      hs_if.height_in  = 8'h00;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_x",       int'(pipe_x), 640);
      check("rst_gap_top", int'(gap_top), 160);
      check("rst_gap_bot", int'(gap_bot), 280);
      check("rst_req",     int'(hs_if.height_req), 0);
      check("rst_passed",  int'(passed), 0);
      check("rst_busy",    int'(busy), 0);
      reset = 1'b0;

      // IDLE -> REQ on a tick with run=1
      @(negedge clk) begin run = 1'b1; frame_tick = 1'b1; end
      @(negedge clk) frame_tick = 1'b0;
      check("idle_req",  int'(hs_if.height_req), 1);
      check("idle_busy", int'(busy), 1);

      // run=0 and ticks in REQ keep the request pending
      run = 1'b0;
      @(negedge clk) frame_tick = 1'b1;
      @(negedge clk) frame_tick = 1'b0;
      repeat (2) @(negedge clk);
      check("req_hold_req", int'(hs_if.height_req), 1);
      check("req_hold_x",   int'(pipe_x), 640);

      // Ack with run=0 still completes the load: height 0 -> 40/160
      do_ack("ack0", 0, 1'b0);
      run = 1'b1;

      // Spurious ack in SCROLL is ignored
      @(negedge clk) begin hs_if.height_ack = 1'b1; hs_if.height_in = 8'd200; end
      @(negedge clk) hs_if.height_ack = 1'b0;
      check("spur_gap_top", int'(gap_top), 40);
      check("spur_gap_bot", int'(gap_bot), 160);
      check("spur_x",       int'(pipe_x), 640);

      // run=0 freezes scrolling across 10 ticks
      run = 1'b0;
      repeat (10) begin
         @(negedge clk) frame_tick = 1'b1;
         @(negedge clk) frame_tick = 1'b0;
      end
      check("freeze_x",      int'(pipe_x), 640);
      check("freeze_passed", int'(pass_cnt), 0);
      run = 1'b1;

      // Full pass: 352 ticks from respawn to the next request
      for (int i = 1; i <= 352; i++) begin
         tick_scroll("pass1");
         if (i == 351) check("pass1_t351_x", int'(pipe_x), -62);
      end
      check("pass1_end_x",   int'(pipe_x), -64);
      check("pass1_end_req", int'(hs_if.height_req), 1);
      check("pass1_pulses",  pass_cnt, 1);

      // Simultaneous tick and ack: ack wins, tick dropped; height 255 -> 279/399
      do_ack("ack255", 255, 1'b1);
      tick_scroll("after_ack");

      // Scroll back off-screen, gap bounds stay stable
      for (int i = 2; i <= 352; i++) tick_scroll("pass2");
      check("pass2_gap_top", int'(gap_top), 279);
      check("pass2_gap_bot", int'(gap_bot), 399);
      check("pass2_req",     int'(hs_if.height_req), 1);
      check("pass2_pulses",  pass_cnt, 2);

      // Asynchronous reset mid-REQ, checked between clock edges
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("areset_req",     int'(hs_if.height_req), 0);
      check("areset_x",       int'(pipe_x), 640);
      check("areset_gap_top", int'(gap_top), 160);
      check("areset_busy",    int'(busy), 0);
      @(negedge clk) reset = 1'b0;

      // Back through IDLE -> REQ, height 128 -> 160/280
      @(negedge clk) frame_tick = 1'b1;
      @(negedge clk) frame_tick = 1'b0;
      check("idle2_req", int'(hs_if.height_req), 1);
      do_ack("ack128", 128, 1'b0);

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_scroller.md
# pipe_scroller

Obstacle (pipe) position and height controller for the side-scrolling game. Scrolls one pipe leftward by a fixed step each frame. When the pipe leaves the screen, it requests a fresh random height from the height generator over a req/ack handshake and respawns at the right edge. It also emits the vertical gap bounds to the renderer and the collision logic, plus a one-cycle score pulse when the pipe passes the bird.

## Interface
Parameters:
- SCREEN_W, 640: visible width in pixels; respawn x.
- PIPE_W, 64: pipe width in pixels.
- SPEED, 2: pixels moved per frame_tick.
- GAP, 120: vertical opening height in pixels.
- MIN_TOP, 40: smallest gap_top value.
- RANGE, 240: span of gap_top above MIN_TOP.
- BIRD_X, 160: x of bird's left edge, used for the score pulse.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high; one clock domain.
- run  in  1  game running; 0 freezes scrolling.
- frame_tick  in  1  one-cycle pulse per video frame.
- height_in  in  8  random value from the height generator; valid when height_ack=1.
- height_ack  in  1  generator acknowledges; height_in valid this cycle.
- height_req  out  1  registered request for a new height.
- pipe_x  out  11  signed left edge of the pipe, in pixels.
- gap_top  out  9  y of the top of the opening.
- gap_bot  out  9  y of the bottom of the opening; always gap_top+GAP.
- passed  out  1  one-cycle pulse when the pipe clears BIRD_X.
- busy  out  1  high in REQ state.

## Operation
- FSM states: IDLE, REQ, SCROLL.
- Reset values: state=IDLE, pipe_x=SCREEN_W, gap_top=MIN_TOP+RANGE/2 (160), gap_bot=280, height_req=0, passed=0, busy=0.
- IDLE: on frame_tick && run → REQ, with height_req←1 registered.
- REQ:
  - height_req is held at 1 until height_ack is sampled 1 while height_req=1.
  - On that cycle: gap_top←MIN_TOP+((height_in*RANGE)>>8) (16-bit product, 9-bit result, range 40..279); gap_bot←gap_top_new+GAP; pipe_x←SCREEN_W; height_req←0; → SCROLL.
  - run=0 does not abort the handshake.
  - frame_tick is ignored in REQ.
- SCROLL: on frame_tick && run:
  - nx = pipe_x−SPEED (signed 11-bit); pipe_x←nx.
  - If nx+PIPE_W ≤ 0 → REQ (height_req←1 next edge).
  - If pipe_x+PIPE_W > BIRD_X and nx+PIPE_W ≤ BIRD_X, passed←1 for exactly one cycle.
  - run=0 or no tick: hold all values.
- height_ack while height_req=0 is ignored; height_in is sampled only on the accepting cycle.
- gap_top and gap_bot change only on handshake completion or reset. They stay stable through scrolling.
- Reset asserted mid-handshake returns to IDLE with height_req=0 immediately (asynchronous). The generator must tolerate a dropped request.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- IDLE→REQ: height_req rises on the edge that samples frame_tick && run.
- Handshake: ack sampled at edge N (req=1) → at edge N: req=0, gap_* valid, pipe_x=SCREEN_W, state=SCROLL. Minimum REQ dwell is one cycle.
- Scroll update: pipe_x is valid one cycle after the frame_tick edge. passed pulses on that same edge.
- Offscreen detection and entry into REQ occur on the same edge as the final scroll step.
- Simultaneous frame_tick and height_ack in REQ: ack wins and the tick is dropped. The first scroll step happens on the next tick.
- Full cycle length for the defaults: (640+64)/2 = 352 ticks from respawn to the next request.

## Test plan
- Reset, then run=1 with one frame_tick: height_req=1 next cycle. Ack with height_in=0 → gap_top=40, gap_bot=160, pipe_x=640, req=0.
- height_in=255 acked → gap_top=40+239=279, gap_bot=399. height_in=128 → gap_top=160, gap_bot=280.
- 352 ticks after respawn: pipe_x=−64 and height_req=1 on the same edge. Tick 351 leaves pipe_x=−62 and req=0.
- passed pulses exactly once per pass, on the tick that moves pipe_x from 98 to 96 (right edge 162→160), width one cycle.
- run=0 during SCROLL freezes pipe_x across 10 ticks. run=0 during REQ keeps req=1, and an ack still completes the load.
- Spurious ack while in SCROLL leaves gap_top unchanged. Async reset asserted mid-REQ drops req to 0 immediately and restores pipe_x=640, gap_top=160.
